// File: rtl/rgb2gray_pkg.sv
// Shared constants, types and the shift/round/saturate helper for rgb2gray_pipe.
// Optional feature macro: RGB2GRAY_ROUND_EN (round-half-up before the shift).
package rgb2gray_pkg;

  // Pipeline depth from input sample to registered output.
  localparam int LAT = 3;

  // Default coefficients expressed for COEF_W=8 (BT.601 luma weights).
  localparam int DEF_CR = 77;
  localparam int DEF_CG = 150;
  localparam int DEF_CB = 29;

  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B, SEL_NONE} coef_sel_e;

  // Rescale an 8-fractional-bit default to coef_w fractional bits.
  function automatic int def_coef(input int c8, input int coef_w);
    if (coef_w >= 8) return c8 << (coef_w - 8);
    else             return c8 >> (8 - coef_w);
  endfunction

  // Drop the fractional bits (optionally rounding first) and clamp to the
  // pixel range; rounding happens before the clamp so 255.5 still saturates.
  function automatic logic [31:0] sat_shift(input logic [63:0] sum,
                                            input int coef_w,
                                            input int pix_w);
    logic [63:0] s;
    logic [63:0] mx;
    s = sum;
`ifdef RGB2GRAY_ROUND_EN
    s = s + (64'd1 << (coef_w - 1));
`else
    s = s + 64'd0;
`endif
    s  = s >> coef_w;
    mx = (64'd1 << pix_w) - 64'd1;
    if (s > mx) s = mx;
    return s[31:0];
  endfunction

endpackage

// File: rtl/rgb2gray_coef_bank.sv
// Double-buffered coefficient store: writes land in the pending bank, and a
// frame-start commit copies pending into active. The commit-cycle pixel sees
// the pending values through the output mux, so it already uses them.
module rgb2gray_coef_bank
  import rgb2gray_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_coef_we,
  input  logic [1:0]        i_coef_sel,
  input  logic [COEF_W-1:0] i_coef,
  input  logic              i_commit,
  output logic [COEF_W-1:0] o_cr,
  output logic [COEF_W-1:0] o_cg,
  output logic [COEF_W-1:0] o_cb,
  output logic              o_coef_pend
);

  localparam logic [COEF_W-1:0] W_DEF_R = COEF_W'(def_coef(DEF_CR, COEF_W));
  localparam logic [COEF_W-1:0] W_DEF_G = COEF_W'(def_coef(DEF_CG, COEF_W));
  localparam logic [COEF_W-1:0] W_DEF_B = COEF_W'(def_coef(DEF_CB, COEF_W));

  coef_sel_e         w_sel;
  logic              w_wr;
  logic [COEF_W-1:0] r_pend_r, r_pend_g, r_pend_b;
  logic [COEF_W-1:0] r_act_r,  r_act_g,  r_act_b;
  logic              r_pend;

  assign w_sel = coef_sel_e'(i_coef_sel);
  assign w_wr  = i_coef_we && (w_sel != SEL_NONE);

  // Pending bank: write decode; SEL_NONE never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_r <= W_DEF_R;
      r_pend_g <= W_DEF_G;
      r_pend_b <= W_DEF_B;
    end else if (i_coef_we) begin
      case (w_sel)
        SEL_R:   r_pend_r <= i_coef;
        SEL_G:   r_pend_g <= i_coef;
        SEL_B:   r_pend_b <= i_coef;
        default: ;
      endcase
    end
  end

  // Active bank: commit copies the pre-write pending values (NBA ordering).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_r <= W_DEF_R;
      r_act_g <= W_DEF_G;
      r_act_b <= W_DEF_B;
    end else if (i_commit) begin
      r_act_r <= r_pend_r;
      r_act_g <= r_pend_g;
      r_act_b <= r_pend_b;
    end
  end

  // Pending flag: a write wins over a same-cycle commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_pend <= 1'b0;
    else if (w_wr)     r_pend <= 1'b1;
    else if (i_commit) r_pend <= 1'b0;
  end

  assign o_cr        = i_commit ? r_pend_r : r_act_r;
  assign o_cg        = i_commit ? r_pend_g : r_act_g;
  assign o_cb        = i_commit ? r_pend_b : r_act_b;
  assign o_coef_pend = r_pend;

endmodule

// File: rtl/rgb2gray_pipe.sv
// RGB to grayscale converter, fixed 3-stage pipeline:
//   S1 products, S2 sum, S3 shift/saturate to o_gray.
// Valid and SOF ride a shift register alongside the data; each stage's data
// only loads when its valid bit is set, so o_gray holds across gaps.
// Optional feature macro: RGB2GRAY_ROUND_EN (round-half-up in S3).
module rgb2gray_pipe
  import rgb2gray_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_DVAL,
  input  logic              i_SOF,
  input  logic [PIX_W-1:0]  i_Red,
  input  logic [PIX_W-1:0]  i_Green,
  input  logic [PIX_W-1:0]  i_Blue,
  input  logic              i_coef_we,
  input  logic [1:0]        i_coef_sel,
  input  logic [COEF_W-1:0] i_coef,
  output logic              o_DVAL,
  output logic              o_SOF,
  output logic [PIX_W-1:0]  o_gray,
  output logic              o_coef_pend
);

  localparam int PROD_W = PIX_W + COEF_W;
  localparam int SUM_W  = PIX_W + COEF_W + 2;

  logic              w_commit;
  logic [COEF_W-1:0] w_cr, w_cg, w_cb;
  logic [PIX_W-1:0]  w_gray;

  logic [LAT:1]      r_vld;
  logic [LAT:1]      r_sof;
  logic [PROD_W-1:0] r_pr, r_pg, r_pb;
  logic [SUM_W-1:0]  r_sum;
  logic [PIX_W-1:0]  r_gray;

  // SOF only counts on a valid pixel.
  assign w_commit = i_DVAL & i_SOF;

  rgb2gray_coef_bank #(.COEF_W(COEF_W)) u_coef (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_coef_we  (i_coef_we),
    .i_coef_sel (i_coef_sel),
    .i_coef     (i_coef),
    .i_commit   (w_commit),
    .o_cr       (w_cr),
    .o_cg       (w_cg),
    .o_cb       (w_cb),
    .o_coef_pend(o_coef_pend)
  );

  // Valid/SOF shift register; reset drops any in-flight pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_sof <= '0;
    end else begin
      r_vld <= {r_vld[LAT-1:1], i_DVAL};
      r_sof <= {r_sof[LAT-1:1], w_commit};
    end
  end

  // S1: per-channel products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pr <= '0;
      r_pg <= '0;
      r_pb <= '0;
    end else if (i_DVAL) begin
      r_pr <= PROD_W'(i_Red)   * PROD_W'(w_cr);
      r_pg <= PROD_W'(i_Green) * PROD_W'(w_cg);
      r_pb <= PROD_W'(i_Blue)  * PROD_W'(w_cb);
    end
  end

  // S2: sum with two guard bits so three full-scale products cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sum <= '0;
    else if (r_vld[1]) r_sum <= SUM_W'(r_pr) + SUM_W'(r_pg) + SUM_W'(r_pb);
  end

  assign w_gray = PIX_W'(sat_shift(64'(r_sum), COEF_W, PIX_W));

  // S3: shifted, saturated result; holds while no valid pixel arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_gray <= '0;
    else if (r_vld[2]) r_gray <= w_gray;
  end

  assign o_DVAL = r_vld[LAT];
  assign o_SOF  = r_sof[LAT];
  assign o_gray = r_gray;

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Directed + randomized bench for rgb2gray_pipe with a behavioural model:
// coefficient banks as plain arrays, gray computed with integer arithmetic,
// outputs predicted through a 3-deep expectation queue.
module tb_rgb2gray_pipe;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_DVAL, i_SOF;
  logic [PIX_W-1:0]  i_Red, i_Green, i_Blue;
  logic              i_coef_we;
  logic [1:0]        i_coef_sel;
  logic [COEF_W-1:0] i_coef;
  logic              o_DVAL, o_SOF, o_coef_pend;
  logic [PIX_W-1:0]  o_gray;

  int checks = 0;
  int errors = 0;

  // Model state
  int unsigned m_act[3];
  int unsigned m_pend[3];
  bit          m_pf;
  bit          qv[$];
  bit          qs[$];
  int unsigned qg[$];
  int unsigned last_gray;

  rgb2gray_pipe #(.PIX_W(PIX_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_DVAL(i_DVAL), .i_SOF(i_SOF),
    .i_Red(i_Red), .i_Green(i_Green), .i_Blue(i_Blue),
    .i_coef_we(i_coef_we), .i_coef_sel(i_coef_sel), .i_coef(i_coef),
    .o_DVAL(o_DVAL), .o_SOF(o_SOF), .o_gray(o_gray), .o_coef_pend(o_coef_pend)
  );

  always #5 clk = ~clk;

  function automatic int unsigned ref_gray(int unsigned r, g, b, cr, cg, cb);
    longint unsigned s;
    s = longint'(r) * cr + longint'(g) * cg + longint'(b) * cb;
`ifdef RGB2GRAY_ROUND_EN
    s = s + (longint'(1) << (COEF_W - 1));
`endif
    s = s >> COEF_W;
    if (s > (longint'(1) << PIX_W) - 1) s = (longint'(1) << PIX_W) - 1;
    return int'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qv.delete(); qs.delete(); qg.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      qv.push_back(1'b0); qs.push_back(1'b0); qg.push_back(0);
    end
    last_gray = 0;
    m_act  = '{77, 150, 29};
    m_pend = '{77, 150, 29};
    m_pf   = 1'b0;
  endtask

  // One clock: drive at negedge, advance model, check #1 after posedge.
  task automatic step(input bit dv, input bit sof, input int unsigned r, g, b,
                      input bit we, input int unsigned sel, input int unsigned cf);
    bit          cm, ev, es;
    int unsigned eg;
    @(negedge clk);
    i_DVAL = dv; i_SOF = sof;
    i_Red = PIX_W'(r); i_Green = PIX_W'(g); i_Blue = PIX_W'(b);
    i_coef_we = we; i_coef_sel = 2'(sel); i_coef = COEF_W'(cf);
    cm = dv && sof;
    qv.push_back(dv);
    qs.push_back(cm);
    if (cm) qg.push_back(ref_gray(r, g, b, m_pend[0], m_pend[1], m_pend[2]));
    else    qg.push_back(ref_gray(r, g, b, m_act[0], m_act[1], m_act[2]));
    if (cm) begin m_act = m_pend; m_pf = 1'b0; end
    if (we && sel < 3) begin m_pend[sel] = cf; m_pf = 1'b1; end
    @(posedge clk); #1;
    ev = qv.pop_front(); es = qs.pop_front(); eg = qg.pop_front();
    if (ev) last_gray = eg;
    chk("dval", 32'(o_DVAL), 32'(ev));
    chk("sof",  32'(o_SOF),  32'(es));
    chk("gray", 32'(o_gray), last_gray);
    chk("pend", 32'(o_coef_pend), 32'(m_pf));
  endtask

  task automatic px(input bit sof, input int unsigned r, g, b);
    step(1'b1, sof, r, g, b, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic wr(input int unsigned sel, input int unsigned cf);
    step(1'b0, 1'b0, 0, 0, 0, 1'b1, sel, cf);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear immediately.
  task automatic hw_reset(input int cyc);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dval", 32'(o_DVAL), 0);
    chk("rst_sof",  32'(o_SOF), 0);
    chk("rst_gray", 32'(o_gray), 0);
    chk("rst_pend", 32'(o_coef_pend), 0);
    i_DVAL = 1'b0; i_SOF = 1'b0; i_coef_we = 1'b0;
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    i_DVAL = 0; i_SOF = 0; i_Red = 0; i_Green = 0; i_Blue = 0;
    i_coef_we = 0; i_coef_sel = 0; i_coef = 0;
    hw_reset(3);

    // 1: white pixel, appears 3 edges later saturating at 255
    px(1'b0, 255, 255, 255);
    idle(1);
    chk("t1_early", 32'(o_DVAL), 0);
    idle(1);
    chk("t1_dval", 32'(o_DVAL), 1);
    chk("t1_gray", 32'(o_gray), 255);
    idle(2);

    // 2: known sums
    px(1'b0, 100, 50, 25);
    idle(2);
    chk("t2_62", 32'(o_gray), 62);
    px(1'b0, 0, 1, 0);
    idle(2);
`ifdef RGB2GRAY_ROUND_EN
    chk("t2_round", 32'(o_gray), 1);
`else
    chk("t2_trunc", 32'(o_gray), 0);
`endif

    // 3: all coefs 255, SOF pixel commits and already uses them
    wr(0, 255); wr(1, 255); wr(2, 255);
    chk("t3_pend1", 32'(o_coef_pend), 1);
    px(1'b1, 255, 255, 255);
    chk("t3_pend0", 32'(o_coef_pend), 0);
    px(1'b0, 100, 50, 25);
    idle(1);
    chk("t3_sat", 32'(o_gray), 255);
    idle(1);
    chk("t3_new", 32'(o_gray), 174);

    // 4: restore defaults, then G=0 mid-frame takes effect at next SOF
    wr(0, 77); wr(1, 150); wr(2, 29);
    px(1'b1, 0, 0, 0);
    wr(1, 0);
    px(1'b0, 0, 100, 0);
    idle(2);
`ifdef RGB2GRAY_ROUND_EN
    chk("t4_old", 32'(o_gray), 59);
`else
    chk("t4_old", 32'(o_gray), 58);
`endif
    step(1'b1, 1'b1, 0, 100, 0, 1'b1, 0, 77);
    chk("t4_pend", 32'(o_coef_pend), 1);
    idle(2);
    chk("t4_new", 32'(o_gray), 0);
    px(1'b1, 0, 0, 0);
    wr(1, 150);
    px(1'b1, 0, 0, 0);

    // 5: bubble pattern 1,0,1,1,0
    px(1'b0, 10, 200, 30);
    idle(1);
    px(1'b1, 250, 5, 90);
    px(1'b0, 60, 70, 80);
    idle(4);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 255));

    // 6: reset with two pixels in flight
    wr(1, 3);
    px(1'b0, 200, 200, 200);
    px(1'b0, 100, 100, 100);
    hw_reset(2);
    idle(4);
    chk("t6_gray", 32'(o_gray), 0);
    px(1'b0, 100, 50, 25);
    idle(2);
    chk("t6_act", 32'(o_gray), 62);
    px(1'b1, 100, 50, 25);
    idle(2);
    chk("t6_pend", 32'(o_gray), 62);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
